// File: rtl/serial_nibble_rx_pkg.sv
// Shared types and defaults for the serial nibble receiver.
// State encoding is fixed so the lab's debug probes can decode it directly.
package serial_nibble_rx_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      WAIT_HI = 3'd4
   } rx_state_e;

   localparam int DEF_DATA_W       = 4;
   localparam int DEF_CLKS_PER_BIT = 4;

endpackage

// File: rtl/serial_nibble_rx_sync_2ff.sv
// Two-flop bit synchronizer with a configurable reset value.
// Reusable by any lab input stage that samples an asynchronous line.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_d, meta_q;
   logic sync_d, sync_q;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/serial_nibble_rx.sv
// Framed serial-to-parallel receiver driving a load-enable register (dout->din, load->en).
// Optional even parity bit after the data bits: define SERIAL_NIBBLE_RX_PARITY_EN.
module serial_nibble_rx
   import serial_nibble_rx_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sin,
   output logic [DATA_W-1:0] dout,
   output logic              load,
   output logic              busy,
   output logic              frame_err
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
   ,
   output logic              parity_err
`endif
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = (DATA_W > 0) ? $clog2(DATA_W + 1) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W);
`else
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
`endif

   logic sin_s;

   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (sin),
      .q   (sin_s)
   );

   rx_state_e         state_d, state_q;
   logic [BAUD_W-1:0] baud_d, baud_q;
   logic [BIT_W-1:0]  bit_d, bit_q;
   logic [DATA_W-1:0] shreg_d, shreg_q;
   logic [DATA_W-1:0] dout_d, dout_q;
   logic              load_d, load_q;
   logic              busy_d, busy_q;
   logic              ferr_d, ferr_q;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
   logic              par_d, par_q;
   logic              perr_d, perr_q;
`endif

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      dout_d  = dout_q;
      load_d  = 1'b0;
      ferr_d  = 1'b0;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (!sin_s) state_d = START;
         end

         // Re-check the line at mid start bit to reject glitches.
         START: begin
            if (baud_q == BAUD_HALF) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = sin_s ? IDLE : DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
               if (bit_q == BIT_LAST) begin
                  par_d = sin_s;
               end else begin
                  for (int i = 0; i < DATA_W - 1; i++) shreg_d[i] = shreg_q[i+1];
                  shreg_d[DATA_W-1] = sin_s;
               end
`else
               for (int i = 0; i < DATA_W - 1; i++) shreg_d[i] = shreg_q[i+1];
               shreg_d[DATA_W-1] = sin_s;
`endif
               if (bit_q == BIT_LAST) begin
                  bit_d   = '0;
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         // A bad stop bit outranks a parity failure.
         STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               if (sin_s) begin
                  state_d = IDLE;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
                  if ((^shreg_q) ^ par_q) begin
                     perr_d = 1'b1;
                  end else begin
                     dout_d = shreg_q;
                     load_d = 1'b1;
                  end
`else
                  dout_d = shreg_q;
                  load_d = 1'b1;
`endif
               end else begin
                  ferr_d  = 1'b1;
                  state_d = WAIT_HI;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         // Hold here until the line releases so a stuck-low wire cannot retrigger.
         WAIT_HI: begin
            baud_d = '0;
            bit_d  = '0;
            if (sin_s) state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            baud_d  = '0;
            bit_d   = '0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         dout_q  <= '0;
         load_q  <= 1'b0;
         busy_q  <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         dout_q  <= dout_d;
         load_q  <= load_d;
         busy_q  <= busy_d;
         ferr_q  <= ferr_d;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   // Assembly registers carry data only; the FSM decides when they are used.
   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
      par_q   <= par_d;
`endif
   end

   assign dout      = dout_q;
   assign load      = load_q;
   assign busy      = busy_q;
   assign frame_err = ferr_q;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
   assign parity_err = perr_q;
`endif

endmodule
